// File: rtl/vbuf_arbiter.sv
// Small circular FIFO; head is visible combinationally while not empty.
// Latency: a pushed entry is at the head one cycle after the push.
// Backpressure: the caller pushes only while !full and pops only while !empty.
module vbuf_fifo #(
    parameter int W     = 21,
    parameter int DEPTH = 4
) (
    input  logic         pclk,
    input  logic         rst,
    input  logic         push_vld,
    input  logic [W-1:0] push_dat,
    input  logic         pop_vld,
    output logic [W-1:0] head_dat,
    output logic         empty,
    output logic         full
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [W-1:0]  mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [CW-1:0] cnt;

    always_ff @(posedge pclk) begin
        if (push_vld) mem[wr_ptr] <= push_dat;
    end

    always_ff @(posedge pclk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (push_vld) wr_ptr <= wr_ptr + PW'(1);
            if (pop_vld)  rd_ptr <= rd_ptr + PW'(1);
            case ({push_vld, pop_vld})
                2'b10:   cnt <= cnt + CW'(1);
                2'b01:   cnt <= cnt - CW'(1);
                default: cnt <= cnt;
            endcase
        end
    end

    assign head_dat = mem[rd_ptr];
    assign empty    = (cnt == '0);
    assign full     = (cnt == CW'(DEPTH));
endmodule

// Single-port video buffer arbiter: scanout read > clear fill > buffered host writes.
// Latency: scanout data returns 2 cycles after sc_req; host writes retire in idle RAM cycles.
// Backpressure: wr_ready drops when the FIFO is full or a clear is running; scanout never stalls.
module vbuf_arbiter #(
    parameter int NPIX        = 4800,
    parameter int AW          = 13,
    parameter int DW          = 8,
    parameter int FIFO_DEPTH  = 4,
    parameter int HOLD_VBLANK = 0
) (
    input  logic          pclk,
    input  logic          rst,
    input  logic          vblank,
    input  logic          sc_req,
    input  logic [AW-1:0] sc_addr,
    output logic [DW-1:0] sc_rdata,
    output logic          sc_rvalid,
    input  logic          wr_valid,
    output logic          wr_ready,
    input  logic [AW-1:0] wr_addr,
    input  logic [DW-1:0] wr_data,
    input  logic          clr_start,
    input  logic [DW-1:0] clr_color,
    output logic          clr_busy,
    output logic          clr_done,
    output logic          err_oor,
    output logic [AW-1:0] ram_addr,
    output logic          ram_we,
    output logic [DW-1:0] ram_wdata,
    input  logic [DW-1:0] ram_rdata
);
    localparam logic [AW-1:0] NPIX_A = AW'(NPIX);
    localparam logic [AW-1:0] LAST_A = AW'(NPIX - 1);
    localparam logic [0:0] CLR_IDLE = 1'b0;
    localparam logic [0:0] CLR_FILL = 1'b1;

    logic [0:0]       clr_state;
    logic [AW-1:0]    clr_cnt;
    logic [DW-1:0]    clr_col;
    logic             sc_req_d;
    logic             fifo_push;
    logic             fifo_empty;
    logic             fifo_full;
    logic [AW+DW-1:0] head_dat;
    logic [AW-1:0]    head_addr;
    logic [DW-1:0]    head_wdat;
    logic             window;
    logic             grant_clr;
    logic             grant_host;
    logic             host_in_range;
    logic             clr_accept;

    assign head_addr     = head_dat[AW+DW-1:DW];
    assign head_wdat     = head_dat[DW-1:0];
    assign window        = (HOLD_VBLANK == 0) ? 1'b1 : vblank;
    assign clr_busy      = (clr_state == CLR_FILL);
    assign grant_clr     = !sc_req && clr_busy && window;
    assign grant_host    = !sc_req && !clr_busy && !fifo_empty && window;
    assign host_in_range = (head_addr < NPIX_A);
    assign wr_ready      = !fifo_full && !clr_busy;
    assign fifo_push     = wr_valid && wr_ready;
    // A push in the same cycle means the FIFO will not be empty, so the clear is refused.
    assign clr_accept    = clr_start && fifo_empty && !clr_busy && !fifo_push;

    vbuf_fifo #(.W(AW + DW), .DEPTH(FIFO_DEPTH)) u_fifo (
        .pclk     (pclk),
        .rst      (rst),
        .push_vld (fifo_push),
        .push_dat ({wr_addr, wr_data}),
        .pop_vld  (grant_host),
        .head_dat (head_dat),
        .empty    (fifo_empty),
        .full     (fifo_full)
    );

    always_comb begin
        ram_addr  = '0;
        ram_we    = 1'b0;
        ram_wdata = '0;
        if (sc_req) begin
            ram_addr = sc_addr;
        end else if (grant_clr) begin
            ram_addr  = clr_cnt;
            ram_we    = 1'b1;
            ram_wdata = clr_col;
        end else if (grant_host) begin
            ram_addr  = head_addr;
            ram_we    = host_in_range;
            ram_wdata = head_wdat;
        end
        if (rst) ram_we = 1'b0;
    end

    always_ff @(posedge pclk) begin
        if (rst) begin
            sc_req_d  <= 1'b0;
            sc_rvalid <= 1'b0;
            sc_rdata  <= '0;
            clr_state <= CLR_IDLE;
            clr_cnt   <= '0;
            clr_col   <= '0;
            clr_done  <= 1'b0;
            err_oor   <= 1'b0;
        end else begin
            sc_req_d  <= sc_req;
            sc_rvalid <= sc_req_d;
            if (sc_req_d) sc_rdata <= ram_rdata;
            clr_done <= 1'b0;
            if (clr_accept) begin
                clr_state <= CLR_FILL;
                clr_cnt   <= '0;
                clr_col   <= clr_color;
            end else if (grant_clr) begin
                if (clr_cnt == LAST_A) begin
                    clr_state <= CLR_IDLE;
                    clr_cnt   <= '0;
                    clr_done  <= 1'b1;
                end else begin
                    clr_cnt <= clr_cnt + AW'(1);
                end
            end
            if (grant_host && !host_in_range) err_oor <= 1'b1;
        end
    end
endmodule

// File: tb/tb_vbuf_arbiter.sv
// Directed bench for vbuf_arbiter with a behavioural synchronous RAM and a
// queue-based scoreboard that checks every RAM write and every scanout return.
module tb_vbuf_arbiter;
    localparam int AW = 13;
    localparam int DW = 8;

    logic          pclk = 1'b0;
    logic          rst = 1'b1;
    logic          vblank = 1'b1;
    logic          sc_req = 1'b0;
    logic [AW-1:0] sc_addr = '0;
    logic [DW-1:0] sc_rdata;
    logic          sc_rvalid;
    logic          wr_valid = 1'b0;
    logic          wr_ready;
    logic [AW-1:0] wr_addr = '0;
    logic [DW-1:0] wr_data = '0;
    logic          clr_start = 1'b0;
    logic [DW-1:0] clr_color = '0;
    logic          clr_busy;
    logic          clr_done;
    logic          err_oor;
    logic [AW-1:0] ram_addr;
    logic          ram_we;
    logic [DW-1:0] ram_wdata;
    logic [DW-1:0] ram_rdata = '0;

    logic [DW-1:0]    mem [8192];
    logic [AW+DW-1:0] exp_wr [$];
    logic [DW-1:0]    exp_rd [$];
    int               exp_rcyc [$];
    int cyc = 0;
    int nvec = 0;
    int nfail = 0;
    int n_we = 0;
    int n_rv = 0;

    vbuf_arbiter #(.NPIX(4800), .AW(AW), .DW(DW), .FIFO_DEPTH(4), .HOLD_VBLANK(1)) dut (
        .pclk(pclk), .rst(rst), .vblank(vblank),
        .sc_req(sc_req), .sc_addr(sc_addr), .sc_rdata(sc_rdata), .sc_rvalid(sc_rvalid),
        .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr), .wr_data(wr_data),
        .clr_start(clr_start), .clr_color(clr_color), .clr_busy(clr_busy), .clr_done(clr_done),
        .err_oor(err_oor), .ram_addr(ram_addr), .ram_we(ram_we), .ram_wdata(ram_wdata),
        .ram_rdata(ram_rdata)
    );

    always #5 pclk = ~pclk;

    initial begin
        for (int i = 0; i < 8192; i++) mem[i] = '0;
    end

    always @(posedge pclk) begin
        cyc <= cyc + 1;
        if (ram_we) mem[ram_addr] <= ram_wdata;
        ram_rdata <= mem[ram_addr];
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Monitor: pops the scoreboard whenever the DUT writes the RAM or returns scan data.
    always @(negedge pclk) begin
        if (ram_we) begin
            n_we++;
            if (rst) chk("we_in_reset", 32'(ram_we), 32'd0);
            else if (exp_wr.size() == 0) chk("unexp_write", {19'd0, ram_addr}, 32'hFFFF);
            else chk("ram_write", 32'({ram_addr, ram_wdata}), 32'(exp_wr.pop_front()));
        end
        if (sc_rvalid) begin
            n_rv++;
            if (exp_rd.size() == 0) chk("unexp_rvalid", 32'(sc_rdata), 32'hFFFF);
            else begin
                chk("scan_data", 32'(sc_rdata), 32'(exp_rd.pop_front()));
                chk("scan_lat", 32'(cyc), 32'(exp_rcyc.pop_front()));
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge pclk);
        #1;
    endtask

    task automatic issue_rd(input logic [AW-1:0] a, input logic [DW-1:0] d);
        sc_req  = 1'b1;
        sc_addr = a;
        exp_rd.push_back(d);
        exp_rcyc.push_back(cyc + 2);
    endtask

    task automatic scan_rd(input logic [AW-1:0] a, input logic [DW-1:0] d);
        issue_rd(a, d);
        tick();
        sc_req = 1'b0;
    endtask

    task automatic host_wr(input logic [AW-1:0] a, input logic [DW-1:0] d, input bit expect_we);
        int b;
        wr_valid = 1'b1;
        wr_addr  = a;
        wr_data  = d;
        b = 0;
        while (!wr_ready && b < 50) begin
            tick();
            b++;
        end
        if (b == 50) chk("wr_ready_timeout", 32'(wr_ready), 32'd1);
        else if (expect_we) exp_wr.push_back({a, d});
        tick();
        wr_valid = 1'b0;
    endtask

    initial begin
        int nwe;
        int bad_rdy;
        int k;
        bit done;
        bit found;
        logic [AW-1:0] rd_a [3];
        logic [DW-1:0] rd_d [3];
        rd_a[0] = 13'h0000; rd_d[0] = 8'hE0;
        rd_a[1] = 13'h12BF; rd_d[1] = 8'h1C;
        rd_a[2] = 13'h0050; rd_d[2] = 8'h03;

        // Reset and idle
        repeat (3) tick();
        rst = 1'b0;
        chk("rst_rvalid", 32'(sc_rvalid), 32'd0);
        chk("rst_rdata", 32'(sc_rdata), 32'd0);
        chk("rst_err", 32'(err_oor), 32'd0);
        chk("rst_done", 32'(clr_done), 32'd0);
        for (int i = 0; i < 10; i++) begin
            @(negedge pclk);
            chk("idle_wr_ready", 32'(wr_ready), 32'd1);
            chk("idle_busy", 32'(clr_busy), 32'd0);
            chk("idle_rvalid", 32'(sc_rvalid), 32'd0);
            chk("idle_we", 32'(ram_we), 32'd0);
            tick();
        end

        // Three host writes, then read one back
        host_wr(13'h0000, 8'hE0, 1'b1);
        host_wr(13'h12BF, 8'h1C, 1'b1);
        host_wr(13'h0050, 8'h03, 1'b1);
        repeat (5) tick();
        chk("hw_retired", 32'(exp_wr.size()), 32'd0);
        scan_rd(13'h12BF, 8'h1C);
        repeat (4) tick();

        // Scanout every cycle starves four queued host writes
        nwe = 0;
        k = n_rv;
        for (int i = 0; i < 20; i++) begin
            issue_rd(rd_a[i % 3], rd_d[i % 3]);
            if (i < 4) begin
                wr_valid = 1'b1;
                wr_addr  = 13'h0100 + 13'(i);
                wr_data  = 8'h10 + 8'(i);
                exp_wr.push_back({wr_addr, wr_data});
            end else begin
                wr_valid = 1'b0;
            end
            if (i == 4 || i == 19) chk("full_wr_ready", 32'(wr_ready), 32'd0);
            @(negedge pclk);
            nwe += int'(ram_we);
            tick();
        end
        sc_req = 1'b0;
        chk("starve_we", 32'(nwe), 32'd0);
        for (int i = 0; i < 4; i++) begin
            @(negedge pclk);
            chk("drain_we", 32'(ram_we), 32'd1);
            tick();
        end
        @(negedge pclk);
        chk("drain_end_we", 32'(ram_we), 32'd0);
        tick();
        tick();
        chk("starve_rvalids", 32'(n_rv - k), 32'd20);

        // Full clear with scanout every 4th cycle and an ignored restart
        k = n_we;
        clr_color = 8'h49;
        clr_start = 1'b1;
        tick();
        clr_start = 1'b0;
        for (int i = 0; i < 4800; i++) exp_wr.push_back({13'(i), 8'h49});
        chk("clr_busy_set", 32'(clr_busy), 32'd1);
        chk("clr_wr_ready", 32'(wr_ready), 32'd0);
        done = 1'b0;
        bad_rdy = 0;
        for (int j = 0; j < 10000 && !done; j++) begin
            if (j % 4 == 0) issue_rd(13'h1FFF, 8'h00);
            else sc_req = 1'b0;
            clr_start = (j == 100);
            clr_color = (j == 100) ? 8'h55 : 8'h49;
            @(negedge pclk);
            if (clr_done) begin
                done = 1'b1;
                chk("done_busy", 32'(clr_busy), 32'd0);
                chk("done_all_written", 32'(exp_wr.size()), 32'd0);
            end else if (wr_ready) begin
                bad_rdy++;
            end
            tick();
        end
        sc_req = 1'b0;
        clr_start = 1'b0;
        chk("clr_finished", 32'(done), 32'd1);
        chk("clr_wr_count", 32'(n_we - k), 32'd4800);
        chk("clr_rdy_low", 32'(bad_rdy), 32'd0);
        @(negedge pclk);
        chk("done_pulse", 32'(clr_done), 32'd0);
        tick();
        repeat (3) tick();
        chk("oor_read_no_err", 32'(err_oor), 32'd0);

        // Out-of-range host write, then valid writes and reads
        host_wr(13'd4800, 8'hAA, 1'b0);
        repeat (3) tick();
        chk("err_set", 32'(err_oor), 32'd1);
        host_wr(13'h0005, 8'h77, 1'b1);
        repeat (3) tick();
        chk("err_sticky", 32'(err_oor), 32'd1);
        scan_rd(13'h0005, 8'h77);
        scan_rd(13'h12BF, 8'h49);
        scan_rd(13'd4799, 8'h49);
        repeat (4) tick();

        // Writes held until vblank
        vblank = 1'b0;
        host_wr(13'h0010, 8'h21, 1'b1);
        host_wr(13'h0011, 8'h22, 1'b1);
        nwe = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge pclk);
            nwe += int'(ram_we);
            tick();
        end
        chk("hold_we", 32'(nwe), 32'd0);
        vblank = 1'b1;
        @(negedge pclk);
        chk("vbl_we0", 32'(ram_we), 32'd1);
        tick();
        @(negedge pclk);
        chk("vbl_we1", 32'(ram_we), 32'd1);
        tick();
        @(negedge pclk);
        chk("vbl_we2", 32'(ram_we), 32'd0);
        tick();

        // Reset discards queued host writes
        vblank = 1'b0;
        host_wr(13'h0020, 8'h01, 1'b0);
        host_wr(13'h0021, 8'h02, 1'b0);
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        vblank = 1'b1;
        chk("rst2_err", 32'(err_oor), 32'd0);
        chk("rst2_wr_ready", 32'(wr_ready), 32'd1);
        repeat (10) tick();

        // Reset mid-clear with the counter at 100
        clr_color = 8'h66;
        clr_start = 1'b1;
        tick();
        clr_start = 1'b0;
        for (int i = 0; i < 100; i++) exp_wr.push_back({13'(i), 8'h66});
        found = 1'b0;
        for (int j = 0; j < 500 && !found; j++) begin
            @(negedge pclk);
            if (ram_we && ram_addr == 13'd99) found = 1'b1;
            tick();
        end
        chk("clr99_seen", 32'(found), 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rst3_busy", 32'(clr_busy), 32'd0);
        chk("rst3_err", 32'(err_oor), 32'd0);
        chk("rst3_wr_ready", 32'(wr_ready), 32'd1);
        repeat (20) tick();
        chk("end_wr_queue", 32'(exp_wr.size()), 32'd0);
        chk("end_rd_queue", 32'(exp_rd.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end
endmodule

// File: doc/vbuf_arbiter.md
Name: vbuf_arbiter

Overview:
Shares the single-port 80x60x8 video buffer RAM (4800 bytes, linear address = row*80 + col) between the VGA scanout fetch path and a host write path. It also provides a hardware clear engine that fills the whole buffer with one colour. Scanout has absolute priority so the pixel pipeline never stalls. Host writes are buffered in a small FIFO and retired in idle RAM cycles, optionally only during vertical blanking for tear-free updates.

Parameters:
NPIX, 4800, number of valid buffer locations (addresses 0..NPIX-1)
AW, 13, RAM address width
DW, 8, pixel width (RRRGGGBB packing is owned by the consumer)
FIFO_DEPTH, 4, host write FIFO entries (power of two, >=2)
HOLD_VBLANK, 0, 1 = host FIFO and clear writes are issued only while vblank=1

Ports:
pclk  in  1  pixel clock; all logic on its rising edge
rst  in  1  synchronous active-high reset
vblank  in  1  1 = vertical blanking interval in progress
sc_req  in  1  scanout read request, single cycle
sc_addr  in  AW  scanout read address
sc_rdata  out  DW  scanout read data
sc_rvalid  out  1  sc_rdata valid, single-cycle pulse
wr_valid  in  1  host write valid
wr_ready  out  1  host write ready
wr_addr  in  AW  host write address
wr_data  in  DW  host write data
clr_start  in  1  start-clear pulse
clr_color  in  DW  clear colour, sampled at accepted clr_start
clr_busy  out  1  clear engine active
clr_done  out  1  single-cycle pulse after the last clear write
err_oor  out  1  sticky flag: a host write address was >= NPIX
ram_addr  out  AW  RAM address (combinational from the grant)
ram_we  out  1  RAM write enable
ram_wdata  out  DW  RAM write data
ram_rdata  in  DW  RAM read data, valid one cycle after the address (synchronous RAM)

Behaviour:
- Reset: the FIFO is emptied. sc_rvalid=0, sc_rdata=0, clr_busy=0, clr_done=0, err_oor=0, clear counter=0. wr_ready=1 in the first cycle after reset. ram_we=0 while rst=1.
- Per-cycle grant, fixed priority: SCAN (sc_req=1) > CLR (clr_busy=1 and window open) > HOST (FIFO non-empty and window open) > IDLE.
- Window open = 1 when HOLD_VBLANK=0, otherwise window open = vblank.
- SCAN: ram_addr=sc_addr, ram_we=0. ram_rdata is registered into sc_rdata, and sc_rvalid=1 exactly 2 cycles after sc_req. Latency is fixed and never stalls.
- sc_addr >= NPIX is still issued to the RAM. The returned data is don't-care, and no error is flagged.
- HOST: pops the FIFO head.
  - If addr < NPIX: ram_we=1, ram_addr=head addr, ram_wdata=head data.
  - If addr >= NPIX: entry is popped, ram_we=0, err_oor is set to 1 and stays set until rst.
- FIFO:
  - wr_ready = (count < FIFO_DEPTH) and not clr_busy, computed from registered state.
  - Push on wr_valid and wr_ready.
  - Push and pop in the same cycle leave count unchanged.
  - Writes retire in acceptance order.
- CLR engine states: IDLE, FILL.
  - IDLE to FILL: on clr_start=1 with FIFO empty and clr_busy=0. Latches clr_color, counter=0, clr_busy=1 from the next cycle.
  - clr_start in any other condition (busy or FIFO non-empty) is ignored with no side effect.
  - FILL: each CLR-granted cycle writes counter address with the latched colour, then counter increments. Cycles lost to SCAN or a closed window leave the counter unchanged.
  - FILL to IDLE: after the write at address NPIX-1. clr_done pulses 1 cycle and clr_busy=0 in that same next cycle, so there are exactly NPIX writes.
- Simultaneous events: sc_req during a FILL or HOST cycle pre-empts it for that cycle only, and nothing is lost. clr_start in the same cycle as a FIFO push is ignored, because the FIFO is non-empty or becomes non-empty.
- rst mid-clear or mid-FIFO: all pending writes are discarded. Writes already issued to the RAM stay as written.
- A HOST write and a SCAN read of the same address never occur in the same cycle (single port). A read granted after a write to the same address returns the new data.

Test Plan:
- Reset, then idle for 10 cycles -> wr_ready=1, clr_busy=0, sc_rvalid=0, ram_we=0 throughout.
- Host writes addr 0x0000=0xE0, 0x12BF=0x1C, 0x0050=0x03 with no sc_req -> three ram_we pulses in order with matching addr/data. Then sc_req addr 0x12BF -> sc_rvalid 2 cycles later with sc_rdata=0x1C.
- sc_req asserted every cycle for 20 cycles while 4 host writes are queued -> ram_we=0 for all 20 cycles, wr_ready=0 after 4 pushes, 20 sc_rvalid pulses, FIFO drains in 4 cycles once sc_req drops.
- clr_start with clr_color=0x49, sc_req every 4th cycle -> exactly 4800 writes of 0x49 to addresses 0..4799 ascending, clr_done after the 4800th write, wr_ready=0 throughout. A second clr_start mid-fill is ignored.
- Host write to addr 4800 -> no ram_we, err_oor=1 and stays 1 through later valid writes until rst.
- HOLD_VBLANK=1 with vblank=0 and 2 queued writes -> no ram_we. Raise vblank -> both writes retire on consecutive cycles.
- Assert rst with clr counter at 100 -> clr_busy=0 next cycle, no further clear writes, FIFO empty, err_oor=0.
